// File: rtl/ir_encode_if.sv
// Start request, payload and status bundle for the NEC IR frame transmitter.
// The Repeat request exists only when IR_REPEAT_EN is defined.
interface ir_encode_if;
  logic        Send_En;
  logic [15:0] irAddr;
  logic [7:0]  irData;
  logic        oIR;
  logic        Busy;
  logic        Tx_Done;
`ifdef IR_REPEAT_EN
  logic        Repeat;

  modport master (output Send_En, irAddr, irData, Repeat, input oIR, Busy, Tx_Done);
  modport slave  (input Send_En, irAddr, irData, Repeat, output oIR, Busy, Tx_Done);
`else
  modport master (output Send_En, irAddr, irData, input oIR, Busy, Tx_Done);
  modport slave  (input Send_En, irAddr, irData, output oIR, Busy, Tx_Done);
`endif
endinterface

// File: rtl/ir_encode.sv
// NEC (HT6221-compatible) IR frame transmitter: leader, 32 data bits LSB first, stop mark, gap.
// Optional repeat-code generation is compiled in with IR_REPEAT_EN.
module ir_encode #(
  parameter int T_LEAD_LOW  = 450000,
  parameter int T_LEAD_HIGH = 225000,
  parameter int T_BIT_LOW   = 28000,
  parameter int T_ZERO_HIGH = 28000,
  parameter int T_ONE_HIGH  = 84500,
  parameter int T_GAP       = 2000000
`ifdef IR_REPEAT_EN
  ,
  parameter int T_REP_HIGH  = 112500
`endif
) (
  input  logic       Clk,
  input  logic       Rst,
  ir_encode_if.slave ir
);

  localparam logic [21:0] LEN_LEAD_LOW  = 22'(T_LEAD_LOW);
  localparam logic [21:0] LEN_LEAD_HIGH = 22'(T_LEAD_HIGH);
  localparam logic [21:0] LEN_BIT_LOW   = 22'(T_BIT_LOW);
  localparam logic [21:0] LEN_ZERO_HIGH = 22'(T_ZERO_HIGH);
  localparam logic [21:0] LEN_ONE_HIGH  = 22'(T_ONE_HIGH);
  localparam logic [21:0] LEN_GAP       = 22'(T_GAP);
`ifdef IR_REPEAT_EN
  localparam logic [21:0] LEN_REP_HIGH  = 22'(T_REP_HIGH);
`endif

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LEAD_LOW  = 4'd1,
    LEAD_HIGH = 4'd2,
    BIT_LOW   = 4'd3,
    BIT_HIGH  = 4'd4,
    STOP      = 4'd5,
    GAP       = 4'd6,
    REP_HIGH  = 4'd7,
    REP_STOP  = 4'd8
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [21:0] cnt_r;
  logic [21:0] cnt_next_s;
  logic [31:0] shift_r;
  logic [31:0] shift_next_s;
  logic [4:0]  idx_r;
  logic [4:0]  idx_next_s;
  logic        oir_r;
  logic        busy_r;
  logic        tx_done_r;
  logic [21:0] phase_len_s;
  logic        phase_end_s;
  logic        level_next_s;
  logic        tx_done_next_s;
  logic        rep_mode_r;
  logic        rep_mode_next_s;

  // Duration of the phase currently being held.
  always_comb begin
    phase_len_s = 22'd1;
    case (state_r)
      LEAD_LOW:  phase_len_s = LEN_LEAD_LOW;
      LEAD_HIGH: phase_len_s = LEN_LEAD_HIGH;
      BIT_LOW:   phase_len_s = LEN_BIT_LOW;
      BIT_HIGH:  phase_len_s = shift_r[0] ? LEN_ONE_HIGH : LEN_ZERO_HIGH;
      STOP:      phase_len_s = LEN_BIT_LOW;
      GAP:       phase_len_s = LEN_GAP;
`ifdef IR_REPEAT_EN
      REP_HIGH:  phase_len_s = LEN_REP_HIGH;
      REP_STOP:  phase_len_s = LEN_BIT_LOW;
`endif
      default:   phase_len_s = 22'd1;
    endcase
  end

  assign phase_end_s = (cnt_r == (phase_len_s - 22'd1));

  // Next-state, counter and shift-register logic.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r + 22'd1;
    shift_next_s    = shift_r;
    idx_next_s      = idx_r;
    rep_mode_next_s = rep_mode_r;
    if (state_r == IDLE) begin
      cnt_next_s = 22'd0;
      if (ir.Send_En) begin
        state_next_s    = LEAD_LOW;
        shift_next_s    = {~ir.irData, ir.irData, ir.irAddr};
        idx_next_s      = 5'd0;
        rep_mode_next_s = 1'b0;
      end else begin
        state_next_s = IDLE;
      end
    end else if (phase_end_s) begin
      cnt_next_s = 22'd0;
      case (state_r)
        LEAD_LOW: begin
`ifdef IR_REPEAT_EN
          state_next_s = rep_mode_r ? REP_HIGH : LEAD_HIGH;
`else
          state_next_s = LEAD_HIGH;
`endif
        end
        LEAD_HIGH: begin
          state_next_s = BIT_LOW;
          idx_next_s   = 5'd0;
        end
        BIT_LOW:   state_next_s = BIT_HIGH;
        BIT_HIGH: begin
          shift_next_s = {1'b0, shift_r[31:1]};
          idx_next_s   = idx_r + 5'd1;
          state_next_s = (idx_r == 5'd31) ? STOP : BIT_LOW;
        end
        STOP:      state_next_s = GAP;
        GAP: begin
`ifdef IR_REPEAT_EN
          // Repeat is sampled only on the last GAP cycle; the flag steers LEAD_LOW to REP_HIGH.
          if (ir.Repeat) begin
            state_next_s    = LEAD_LOW;
            rep_mode_next_s = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
`else
          state_next_s = IDLE;
`endif
        end
`ifdef IR_REPEAT_EN
        REP_HIGH:  state_next_s = REP_STOP;
        REP_STOP:  state_next_s = GAP;
`endif
        default:   state_next_s = IDLE;
      endcase
    end else begin
      cnt_next_s = cnt_r + 22'd1;
    end
  end

  // Output levels are derived from the next state so oIR, Busy and Tx_Done are registered.
  always_comb begin
    level_next_s = 1'b1;
    case (state_next_s)
      LEAD_LOW: level_next_s = 1'b0;
      BIT_LOW:  level_next_s = 1'b0;
      STOP:     level_next_s = 1'b0;
      REP_STOP: level_next_s = 1'b0;
      default:  level_next_s = 1'b1;
    endcase
    tx_done_next_s = (state_next_s == GAP) && (cnt_next_s == (LEN_GAP - 22'd1));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r    <= IDLE;
      cnt_r      <= 22'd0;
      shift_r    <= 32'd0;
      idx_r      <= 5'd0;
      oir_r      <= 1'b1;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
      rep_mode_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      shift_r    <= shift_next_s;
      idx_r      <= idx_next_s;
      oir_r      <= level_next_s;
      busy_r     <= (state_next_s != IDLE);
      tx_done_r  <= tx_done_next_s;
      rep_mode_r <= rep_mode_next_s;
    end
  end

  assign ir.oIR     = oir_r;
  assign ir.Busy    = busy_r;
  assign ir.Tx_Done = tx_done_r;

endmodule

// File: tb/tb_ir_encode.sv
// Scoreboard bench for ir_encode with shortened phase timings: stimulus pushes expected
// waveform segments and Tx_Done cycles; a negedge monitor measures oIR runs and compares.
`timescale 1ns/1ps
module tb_ir_encode;
  localparam int LL = 20;
  localparam int LH = 10;
  localparam int BL = 3;
  localparam int ZH = 2;
  localparam int OH = 5;
  localparam int GP = 12;
  localparam int RH = 7;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  ir_encode_if ir ();

  ir_encode #(
    .T_LEAD_LOW(LL), .T_LEAD_HIGH(LH), .T_BIT_LOW(BL),
    .T_ZERO_HIGH(ZH), .T_ONE_HIGH(OH), .T_GAP(GP)
`ifdef IR_REPEAT_EN
    , .T_REP_HIGH(RH)
`endif
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .ir (ir)
  );

  typedef struct {
    bit is_done;
    bit lvl;
    int len;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int ncyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_seg(input bit lvl, input int len);
    exp_t e;
    e.is_done = 1'b0; e.lvl = lvl; e.len = len;
    q.push_back(e);
  endtask

  task automatic push_done(input int cyc);
    exp_t e;
    e.is_done = 1'b1; e.lvl = 1'b1; e.len = cyc;
    q.push_back(e);
  endtask

  // Monitor: busy/done per cycle, oIR run lengths compared at each level change.
  bit prev_lvl = 1'b1;
  bit skip_high = 1'b1;
  int run = 0;
  always @(negedge Clk) begin
    exp_t e;
    bit exp_done;
    ncyc++;
    if (Rst) begin
      prev_lvl = 1'b1; skip_high = 1'b1; run = 0;
    end else begin
      check("busy", ir.Busy, (q.size() != 0));
      exp_done = (q.size() != 0) && q[0].is_done && (q[0].len == ncyc);
      check("tx_done", ir.Tx_Done, exp_done);
      if (ir.oIR !== prev_lvl) begin
        if (!(prev_lvl && skip_high)) begin
          if (q.size() == 0 || q[0].is_done) begin
            compared++; mismatched++;
            $display("FAIL seg_unexpected: level %0d for %0d cycles, none expected", prev_lvl, run);
          end else begin
            e = q.pop_front();
            check("seg_level", prev_lvl, e.lvl);
            check("seg_len", run, e.len);
          end
        end
        skip_high = 1'b0; prev_lvl = ir.oIR; run = 1;
      end else begin
        run++;
      end
      if (ir.Tx_Done === 1'b1) begin
        if (q.size() != 0 && q[0].is_done) begin
          e = q.pop_front();
          check("gap_len", run, GP);
          check("gap_level", prev_lvl, 1'b1);
        end
        skip_high = 1'b1; run = 0;
      end
    end
  end

  // Caller is aligned just after a posedge; acceptance happens on the next edge.
  task automatic send(input logic [15:0] a, input logic [7:0] d, input int n1, output int done_cyc);
    logic [31:0] sh;
    int x;
    int f;
    ir.Send_En = 1'b1; ir.irAddr = a; ir.irData = d;
    x = ncyc;
    @(posedge Clk); #1;
    ir.Send_En = 1'b0; ir.irAddr = 16'hDEAD; ir.irData = 8'hBE;
    sh = {~d, d, a};
    f = LL + LH + 33 * BL + n1 * OH + (32 - n1) * ZH + GP;
    done_cyc = x + 1 + f;
    push_seg(1'b0, LL);
    push_seg(1'b1, LH);
    for (int i = 0; i < 32; i++) begin
      push_seg(1'b0, BL);
      push_seg(1'b1, sh[i] ? OH : ZH);
    end
    push_seg(1'b0, BL);
    push_done(done_cyc);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && q.size() != 0; i++) begin
      @(posedge Clk); #1;
    end
    if (q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL frame_timeout: %0d expectations left, expected 0", q.size());
      q.delete();
    end
    repeat (3) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic wait_tx_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge Clk); #1;
      if (ir.Tx_Done === 1'b1) found = 1'b1;
    end
    if (!found) begin
      compared++; mismatched++;
      $display("FAIL tx_done_timeout: got no Tx_Done, expected one");
    end
  endtask

  initial begin
    int dc;
    bit found;
    ir.Send_En = 1'b0; ir.irAddr = 16'h0000; ir.irData = 8'h00;
`ifdef IR_REPEAT_EN
    ir.Repeat = 1'b0;
`endif
    // Reset held 5 cycles with Send_En toggling underneath.
    repeat (5) begin
      @(posedge Clk); #1;
      ir.Send_En = ~ir.Send_En;
    end
    ir.Send_En = 1'b0;
    Rst = 1'b0;
    check("reset_oir", ir.oIR, 1'b1);
    check("reset_busy", ir.Busy, 1'b0);
    check("reset_tx_done", ir.Tx_Done, 1'b0);
    repeat (3) begin
      @(posedge Clk); #1;
    end

    send(16'h0001, 8'h12, 9, dc);
    wait_idle();

    // Mid-frame Send_En during bit 0 space must be ignored.
    send(16'h0003, 8'hEB, 10, dc);
    repeat (34) begin
      @(posedge Clk); #1;
    end
    ir.Send_En = 1'b1; ir.irAddr = 16'hFFFF; ir.irData = 8'h00;
    @(posedge Clk); #1;
    ir.Send_En = 1'b0;
    wait_idle();

    send(16'hA55A, 8'h3C, 16, dc);
    wait_idle();

    // Send_En in the Tx_Done cycle is dropped; the first IDLE cycle accepts.
    send(16'hFFFF, 8'hFF, 24, dc);
    wait_tx_done(found);
    ir.Send_En = 1'b1; ir.irAddr = 16'h1234; ir.irData = 8'h56;
    @(posedge Clk); #1;
    ir.Send_En = 1'b0;
    check("busy_after_done", ir.Busy, 1'b0);
    send(16'h0000, 8'h00, 8, dc);
    wait_idle();

    // Reset during LEAD_HIGH aborts; Send_En alongside Rst is ignored.
    send(16'h0001, 8'h12, 9, dc);
    repeat (22) begin
      @(posedge Clk); #1;
    end
    Rst = 1'b1;
    q.delete();
    @(posedge Clk); #1;
    check("abort_oir", ir.oIR, 1'b1);
    check("abort_busy", ir.Busy, 1'b0);
    check("abort_tx_done", ir.Tx_Done, 1'b0);
    ir.Send_En = 1'b1; ir.irAddr = 16'h5555; ir.irData = 8'h55;
    @(posedge Clk); #1;
    Rst = 1'b0;
    ir.Send_En = 1'b0;
    check("rst_send_ignored", ir.Busy, 1'b0);
    repeat (5) begin
      @(posedge Clk); #1;
    end
    send(16'h0001, 8'h12, 9, dc);
    wait_idle();

`ifdef IR_REPEAT_EN
    ir.Repeat = 1'b1;
    send(16'hA55A, 8'h3C, 16, dc);
    push_seg(1'b0, LL);
    push_seg(1'b1, RH);
    push_seg(1'b0, BL);
    push_done(dc + LL + RH + BL + GP);
    wait_tx_done(found);
    @(posedge Clk); #1;
    ir.Repeat = 1'b0;
    wait_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
